// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register: the 3-bit mode type
// and its encoding, used by the register, its step function and any parent
// that drives the mode input.
package universal_shift_register_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'b000;
  localparam mode_t MODE_SHR   = 3'b001;
  localparam mode_t MODE_SHL   = 3'b010;
  localparam mode_t MODE_ROR   = 3'b011;
  localparam mode_t MODE_ROL   = 3'b100;
  localparam mode_t MODE_ASR   = 3'b101;
  localparam mode_t MODE_LOAD  = 3'b110;
  localparam mode_t MODE_CLEAR = 3'b111;

endpackage

// File: rtl/universal_shift_register_step.sv
// One step of the shift register: next register value as a pure function of
// the current value, the operation and the serial/parallel inputs.
module usr_step
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q_next
);

  // Select the next value for the requested operation
  always_comb begin
    q_next = q;
    unique case (mode)
      MODE_HOLD:  q_next = q;
      MODE_SHR:   q_next = {serial_in_left, q[WIDTH-1:1]};
      MODE_SHL:   q_next = {q[WIDTH-2:0], serial_in_right};
      MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_LOAD:  q_next = load_data;
      MODE_CLEAR: q_next = '0;
      default:    q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised bidirectional shift register with direct single-step operation
// and a counted burst mode with busy/done handshake. While idle the live mode
// drives the step; during a burst the mode latched at accept drives it.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_left,
  output logic             serial_out_right,
  output logic             busy,
  output logic             done
);

  mode_t            mode_l;
  logic [CNT_W-1:0] cnt;
  mode_t            step_mode;
  logic [WIDTH-1:0] q_next;
  logic             step_en;

  // Burst uses the latched mode; the accept edge itself never steps
  assign step_mode = busy ? mode_l : mode;
  assign step_en   = en && (busy || !start);

  usr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q              (q),
    .mode           (step_mode),
    .serial_in_left (serial_in_left),
    .serial_in_right(serial_in_right),
    .load_data      (load_data),
    .q_next         (q_next)
  );

  // Register contents: advance one step whenever a direct or burst step is due
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (step_en) begin
      q <= q_next;
    end
  end

  // Burst control: accept on idle start, count en-qualified steps, pulse done
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mode_l <= MODE_HOLD;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          mode_l <= mode;
          cnt    <= shift_count;
          if (shift_count == '0) begin
            done <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
      end else if (en) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign serial_out_left  = q[WIDTH-1];
  assign serial_out_right = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: a 4-bit instance checked
// cycle by cycle against a behavioural model through an expectation queue,
// plus an 8-bit instance for wide burst shifts.
module tb_universal_shift_register;
  import universal_shift_register_pkg::*;

  typedef struct {
    logic [3:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       en, start, sil, sir;
  mode_t      mode;
  logic [3:0] load_data;
  logic [2:0] shift_count;
  logic [3:0] q;
  logic       sol, sor, busy, done;

  logic       w8_en, w8_start, w8_sil, w8_sir;
  mode_t      w8_mode;
  logic [7:0] w8_ld;
  logic [3:0] w8_sc;
  logic [7:0] w8_q;
  logic       w8_sol, w8_sor, w8_busy, w8_done;

  int    n_chk  = 0;
  int    n_fail = 0;
  string phase  = "init";
  exp_t  sb[$];

  logic [3:0] m_q;
  logic       m_busy, m_done;
  logic [2:0] m_cnt;
  mode_t      m_mode;

  always #5 clk1 = ~clk1;

  universal_shift_register #(.WIDTH(4), .CNT_W(3)) dut (
    .clk1(clk1), .rst(rst), .en(en), .mode(mode),
    .serial_in_left(sil), .serial_in_right(sir), .load_data(load_data),
    .start(start), .shift_count(shift_count), .q(q),
    .serial_out_left(sol), .serial_out_right(sor), .busy(busy), .done(done)
  );

  universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk1(clk1), .rst(rst), .en(w8_en), .mode(w8_mode),
    .serial_in_left(w8_sil), .serial_in_right(w8_sir), .load_data(w8_ld),
    .start(w8_start), .shift_count(w8_sc), .q(w8_q),
    .serial_out_left(w8_sol), .serial_out_right(w8_sor), .busy(w8_busy), .done(w8_done)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_step(logic [3:0] c, mode_t m, logic sl, logic sr,
                                          logic [3:0] ld);
    case (m)
      MODE_SHR:   return {sl, c[3], c[2], c[1]};
      MODE_SHL:   return {c[2], c[1], c[0], sr};
      MODE_ROR:   return {c[0], c[3], c[2], c[1]};
      MODE_ROL:   return {c[2], c[1], c[0], c[3]};
      MODE_ASR:   return {c[3], c[3], c[2], c[1]};
      MODE_LOAD:  return ld;
      MODE_CLEAR: return 4'b0000;
      default:    return c;
    endcase
  endfunction

  task automatic model_reset();
    m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_cnt = '0; m_mode = MODE_HOLD;
  endtask

  // Advance the model with the inputs now applied, queue the expectation,
  // then clock the DUT and compare once its outputs have settled.
  task automatic cyc();
    exp_t       e;
    logic [3:0] nq;
    logic       nb, nd;
    nq = m_q; nb = m_busy; nd = 1'b0;
    if (!m_busy) begin
      if (start) begin
        m_mode = mode;
        m_cnt  = shift_count;
        if (shift_count == 3'd0) nd = 1'b1;
        else nb = 1'b1;
      end else if (en) begin
        nq = ref_step(m_q, mode, sil, sir, load_data);
      end
    end else if (en) begin
      nq    = ref_step(m_q, m_mode, sil, sir, load_data);
      m_cnt = m_cnt - 3'd1;
      if (m_cnt == 3'd0) begin
        nb = 1'b0;
        nd = 1'b1;
      end
    end
    m_q = nq; m_busy = nb; m_done = nd;
    e.q = m_q; e.busy = m_busy; e.done = m_done;
    sb.push_back(e);
    @(posedge clk1);
    #1;
    e = sb.pop_front();
    chk_eq("q", 32'(q), 32'(e.q));
    chk_eq("busy", 32'(busy), 32'(e.busy));
    chk_eq("done", 32'(done), 32'(e.done));
    chk_eq("sol", 32'(sol), 32'(e.q[3]));
    chk_eq("sor", 32'(sor), 32'(e.q[0]));
  endtask

  task automatic wait_done8();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk1);
      #1;
      if (w8_done) seen = 1'b1;
    end
    chk_eq("w8_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; start = 1'b0; sil = 1'b0; sir = 1'b0;
    mode = MODE_HOLD; load_data = '0; shift_count = '0;
    w8_en = 1'b0; w8_start = 1'b0; w8_sil = 1'b0; w8_sir = 1'b0;
    w8_mode = MODE_HOLD; w8_ld = '0; w8_sc = '0;
    model_reset();

    phase = "reset";
    #2 rst = 1'b1;
    #1;
    chk_eq("q", 32'(q), 32'd0);
    chk_eq("busy", 32'(busy), 32'd0);
    chk_eq("done", 32'(done), 32'd0);
    @(posedge clk1);
    #1 rst = 1'b0;

    phase = "direct";
    en = 1'b1; mode = MODE_LOAD; load_data = 4'b1011; cyc();
    chk_eq("load_q", 32'(q), 32'hB);
    mode = MODE_SHR; sil = 1'b0; cyc();
    chk_eq("shr_q", 32'(q), 32'h5);
    mode = MODE_SHL; sir = 1'b1; cyc();
    chk_eq("shl_q", 32'(q), 32'hB);
    chk_eq("shl_sol", 32'(sol), 32'd1);
    chk_eq("shl_sor", 32'(sor), 32'd1);
    for (int i = 0; i < 16; i++) begin
      mode = mode_t'(i % 8); sil = 1'($urandom_range(0, 1));
      sir = 1'($urandom_range(0, 1)); load_data = 4'($urandom);
      en = (i != 5); cyc();
    end
    en = 1'b1;

    phase = "ror";
    mode = MODE_LOAD; load_data = 4'b1000; cyc();
    mode = MODE_ROR; shift_count = 3'd3; start = 1'b1; cyc();
    chk_eq("accept_q", 32'(q), 32'h8);
    chk_eq("accept_busy", 32'(busy), 32'd1);
    start = 1'b0; mode = MODE_CLEAR; shift_count = 3'd0;
    cyc(); chk_eq("step1_q", 32'(q), 32'h4);
    cyc(); chk_eq("step2_q", 32'(q), 32'h2);
    cyc(); chk_eq("step3_q", 32'(q), 32'h1);
    chk_eq("step3_done", 32'(done), 32'd1);
    chk_eq("step3_busy", 32'(busy), 32'd0);

    phase = "rol7";
    mode = MODE_ROL; shift_count = 3'd7; start = 1'b1; cyc();
    chk_eq("start_in_done_busy", 32'(busy), 32'd1);
    start = 1'b0; cyc();
    mode = MODE_CLEAR; shift_count = 3'd0; start = 1'b1; cyc();
    chk_eq("start_busy_ignored", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (5) cyc();
    // 0001 rotated left 7 times == rotated left 3 times
    chk_eq("rol7_q", 32'(q), 32'h8);
    chk_eq("rol7_done", 32'(done), 32'd1);

    phase = "stall";
    mode = MODE_LOAD; load_data = 4'b1000; cyc();
    mode = MODE_ASR; shift_count = 3'd2; start = 1'b1; cyc();
    start = 1'b0; cyc();
    chk_eq("asr1_q", 32'(q), 32'hC);
    en = 1'b0; cyc(); cyc();
    chk_eq("stall_q", 32'(q), 32'hC);
    chk_eq("stall_done", 32'(done), 32'd0);
    en = 1'b1; cyc();
    chk_eq("asr2_q", 32'(q), 32'hE);
    chk_eq("asr2_done", 32'(done), 32'd1);

    phase = "zero";
    mode = MODE_SHL; shift_count = 3'd0; start = 1'b1; cyc();
    chk_eq("n0_done", 32'(done), 32'd1);
    chk_eq("n0_busy", 32'(busy), 32'd0);
    chk_eq("n0_q", 32'(q), 32'hE);
    start = 1'b0; mode = MODE_HOLD; cyc();
    chk_eq("n0_done_drop", 32'(done), 32'd0);

    phase = "loadburst";
    mode = MODE_LOAD; load_data = 4'h5; shift_count = 3'd3; start = 1'b1; cyc();
    start = 1'b0; repeat (3) cyc();
    chk_eq("load_burst_q", 32'(q), 32'h5);

    phase = "random";
    for (int i = 0; i < 60; i++) begin
      mode = mode_t'($urandom_range(0, 7)); start = ($urandom_range(0, 3) == 0);
      shift_count = 3'($urandom_range(0, 7)); en = ($urandom_range(0, 3) != 0);
      sil = 1'($urandom_range(0, 1)); sir = 1'($urandom_range(0, 1));
      load_data = 4'($urandom);
      cyc();
    end

    phase = "rst_mid";
    start = 1'b0; en = 1'b1; mode = MODE_HOLD;
    repeat (8) cyc();
    mode = MODE_LOAD; load_data = 4'b0110; cyc();
    mode = MODE_ROL; shift_count = 3'd5; start = 1'b1; cyc();
    start = 1'b0; cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    chk_eq("rst_q", 32'(q), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    model_reset();
    #2 rst = 1'b0;
    repeat (6) begin
      cyc();
      chk_eq("no_done_after_rst", 32'(done), 32'd0);
    end

    phase = "w8";
    en = 1'b0;
    w8_en = 1'b1; w8_mode = MODE_LOAD; w8_ld = 8'hFF;
    @(posedge clk1); #1;
    chk_eq("w8_load", 32'(w8_q), 32'hFF);
    w8_mode = MODE_SHL; w8_sir = 1'b0; w8_sc = 4'd8; w8_start = 1'b1;
    @(posedge clk1); #1;
    w8_start = 1'b0;
    wait_done8();
    chk_eq("w8_shl8", 32'(w8_q), 32'h00);
    w8_mode = MODE_LOAD; w8_ld = 8'h80;
    @(posedge clk1); #1;
    w8_mode = MODE_ASR; w8_sc = 4'd3; w8_start = 1'b1;
    @(posedge clk1); #1;
    w8_start = 1'b0;
    wait_done8();
    chk_eq("w8_asr3", 32'(w8_q), 32'hF0);
    chk_eq("w8_busy", 32'(w8_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
